// File: rtl/mux_striping.sv
// Two-lane receive merge: per-lane elastic FIFOs drained in strict
// lane 0 / lane 1 alternation onto a single registered output stream.
module mux_striping #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_2f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] lane_0,
  input  logic [WIDTH-1:0] lane_1,
  input  logic             valid_in0,
  input  logic             valid_in1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [1:0]       overflow
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [0:0] SEL0 = 1'b0;
  localparam logic [0:0] SEL1 = 1'b1;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];

  logic [AW-1:0] wp0, rp0, wp1, rp1;
  logic [AW:0]   cnt0, cnt1;
  logic [0:0]    sel;

  logic full0, full1, empty0, empty1;
  logic pop0, pop1, push0, push1;
  logic drop0, drop1;

  assign full0  = (cnt0 == CNT_FULL);
  assign full1  = (cnt1 == CNT_FULL);
  assign empty0 = (cnt0 == '0);
  assign empty1 = (cnt1 == '0);

  assign pop0 = (sel == SEL0) && !empty0;
  assign pop1 = (sel == SEL1) && !empty1;

  // A full FIFO still takes a word when it is drained on the same edge.
  assign push0 = valid_in0 && (!full0 || pop0);
  assign push1 = valid_in1 && (!full1 || pop1);
  assign drop0 = valid_in0 && full0 && !pop0;
  assign drop1 = valid_in1 && full1 && !pop1;

  // Storage is only written on an accepted push, so idle lane data never lands.
  always_ff @(posedge clk_2f) begin
    if (push0) mem0[wp0] <= lane_0;
    if (push1) mem1[wp1] <= lane_1;
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wp0  <= '0;
      rp0  <= '0;
      cnt0 <= '0;
    end else begin
      if (push0) wp0 <= wp0 + PTR_ONE;
      if (pop0)  rp0 <= rp0 + PTR_ONE;
      unique case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   cnt0 <= cnt0 - CNT_ONE;
        default: cnt0 <= cnt0;
      endcase
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      wp1  <= '0;
      rp1  <= '0;
      cnt1 <= '0;
    end else begin
      if (push1) wp1 <= wp1 + PTR_ONE;
      if (pop1)  rp1 <= rp1 + PTR_ONE;
      unique case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   cnt1 <= cnt1 - CNT_ONE;
        default: cnt1 <= cnt1;
      endcase
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      overflow <= 2'b00;
    end else begin
      if (drop0) overflow[0] <= 1'b1;
      if (drop1) overflow[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      sel       <= SEL0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      unique case (1'b1)
        pop0: begin
          data_out  <= mem0[rp0];
          valid_out <= 1'b1;
          sel       <= SEL1;
        end
        pop1: begin
          data_out  <= mem1[rp1];
          valid_out <= 1'b1;
          sel       <= SEL0;
        end
        default: valid_out <= 1'b0;
      endcase
    end
  end

endmodule
